// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one pipelined multiplier among NREQ requesters.
// Optional MUL_ARB_STATS_EN adds stat_issued / stat_stall counters.

// Fully pipelined unsigned multiplier: output LAT cycles after inputs, no reset.
module mulparam #(
    parameter int WIDTH = 256,
    parameter int LAT   = 11
) (
    input  logic               clk,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] c
);
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] pipe [LAT];

    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign c    = pipe[LAT-1];

    // Data-only shift register; in-flight products are qualified by the tag pipe.
    always_ff @(posedge clk) begin
        pipe[0] <= prod;
        for (int k = 1; k < LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end
endmodule

module mul_share_arbiter #(
    parameter int WIDTH   = 256,
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 4,
    parameter int MUL_LAT = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_c,
    output logic                  busy
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_stall
`endif
);
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = $clog2(MAX_OUT + 1);
    localparam int DEPTH = MUL_LAT + 1;

    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    cnt [NREQ];
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  retire;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   idx;
    logic             found;
    logic             hs;
    logic [WIDTH-1:0] iss_a;
    logic [WIDTH-1:0] iss_b;
    logic             tag_v  [DEPTH];
    logic [IDW-1:0]   tag_id [DEPTH];

    // Product leaving the multiplier this cycle frees a credit for its owner.
    always_comb begin
        retire = '0;
        if (tag_v[DEPTH-1]) begin
            retire[tag_id[DEPTH-1]] = 1'b1;
        end
    end

    // A credit freed this cycle may be reused by an issue in the same cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = !rst && req_valid[i]
                && (cnt[i] < CW'(MAX_OUT) || retire[i]);
        end
    end

    // First eligible requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && elig[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
    end

    assign hs        = found;
    assign req_ready = grant;
    assign rsp_valid = retire;

    // Pointer advances past the winner only when a handshake happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    // Issue register: selected operands, zeroed when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_a <= '0;
            iss_b <= '0;
        end else if (hs) begin
            iss_a <= req_a[int'(gidx)*WIDTH +: WIDTH];
            iss_b <= req_b[int'(gidx)*WIDTH +: WIDTH];
        end else begin
            iss_a <= '0;
            iss_b <= '0;
        end
    end

    // Tag pipe mirrors issue stage plus multiplier latency; never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= hs;
            tag_id[0] <= gidx;
            for (int k = 1; k < DEPTH; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Per-requester outstanding count: issue adds, retire subtracts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && !retire[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!grant[i] && retire[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Busy while any credit is held or any tag is still in the pipe.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            busy = busy | (cnt[i] != '0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            busy = busy | tag_v[k];
        end
    end

    mulparam #(.WIDTH(WIDTH), .LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .a   (iss_a),
        .b   (iss_b),
        .c   (rsp_c)
    );

`ifdef MUL_ARB_STATS_EN
    // Observation counters: issued wraps, stall saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (hs) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (|req_valid && !hs && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif
endmodule
